// File: rtl/fbs_stack_pkg.sv
// Shared definitions for the f-register backup stack and the register file beside it.
// Holds default geometry and the backup/restore operation decode.
package fbs_stack_pkg;

    localparam int FBS_DATA_W = 256;
    localparam int FBS_DEPTH  = 8;
    localparam int FBS_REG_W  = 16;
    localparam int FBS_NREGS  = 16;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_XCHG = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic backup, input logic restore);
        op_e op;
        case ({backup, restore})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_XCHG;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fbs_stack_mem.sv
// Snapshot storage: DEPTH x DATA_W array, one synchronous write port, one async read port.
// Deliberately not reset; contents are meaningless until written.
module fbs_stack_mem
    import fbs_stack_pkg::*;
#(
    parameter int  DATA_W = FBS_DATA_W,
    parameter int  DEPTH  = FBS_DEPTH,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fbs_stack.sv
// LIFO of f-register file snapshots for nested call/interrupt levels, with occupancy,
// sticky error flags and a defined simultaneous backup+restore (exchange / bypass).
module fbs_stack
    import fbs_stack_pkg::*;
#(
    parameter int  DATA_W = FBS_DATA_W,
    parameter int  DEPTH  = FBS_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              backup,
    input  logic              restore,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              restore_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_restore_out;
    logic              r_overflow;
    logic              r_underflow;

    op_e               w_op;
    logic              w_full;
    logic              w_empty;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_op    = decode_op(backup, restore);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Top-of-stack address from the pre-edge count; exchange reads and overwrites the same slot.
    assign w_raddr = w_empty ? '0 : AW'(r_count - CNT_W'(1));
    assign w_we    = !reset && (((w_op == OP_PUSH) && !w_full) ||
                                ((w_op == OP_XCHG) && !w_empty));
    assign w_waddr = (w_op == OP_PUSH) ? AW'(r_count) : w_raddr;

    fbs_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (data_in),
        .raddr  (w_raddr),
        .rdata  (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_data_out    <= '0;
            r_restore_out <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_restore_out <= 1'b0;
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_data_out    <= w_rdata;
                        r_count       <= r_count - CNT_W'(1);
                        r_restore_out <= 1'b1;
                    end
                end
                OP_XCHG: begin
                    // Empty exchange forwards the incoming image straight through.
                    r_data_out    <= w_empty ? data_in : w_rdata;
                    r_restore_out <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign restore_out = r_restore_out;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
